// File: rtl/padctl_gpio_filter.sv
// ----------------------------------------------------------------------------
// padctl_gpio_filter
//
// Pad-side GPIO conditioning for NumGpio channels:
//   * output path: core data/enables registered once toward the pads
//     (the tristate buffer itself lives in the pad ring)
//   * input path : SyncStages-deep synchroniser, then a per-channel glitch
//     filter with a shared threshold T, then rise/fall edge pulses
//
// Optional build macro: PADCTL_GPIO_LOOPBACK_EN
//   When defined, adds loopback_i. With loopback_i=1 every synchroniser input
//   takes pad_out_o instead of pad_in_i. When undefined, the port and the
//   mux do not exist.
//
// Ports
//   clk_i              clock
//   rst_i              synchronous active-high reset
//   loopback_i         (PADCTL_GPIO_LOOPBACK_EN only) loop pad_out_o to input
//   pad_in_i           raw asynchronous pad inputs
//   pad_out_o          registered pad output values
//   pad_oe_o           registered pad output enables
//   cio_gpio_d2p_i     core output data
//   cio_gpio_en_d2p_i  core output enables
//   cio_gpio_p2d_o     filtered input to the core (the "stable" register)
//   filt_en_i          per-channel filter enable
//   filt_thresh_i      shared filter threshold T
//   edge_rise_o        one-cycle pulse on filtered 0->1
//   edge_fall_o        one-cycle pulse on filtered 1->0
//
// Filter behaviour per channel (enabled): a mismatch between sync and stable
// must persist T+1 consecutive cycles before stable follows sync. Any break
// in the mismatch throws the partial count away.
// ----------------------------------------------------------------------------
module padctl_gpio_filter #(
    parameter int NumGpio    = 16,
    parameter int SyncStages = 2,
    parameter int FiltCntW   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
`ifdef PADCTL_GPIO_LOOPBACK_EN
    input  logic                loopback_i,
`endif
    input  logic [NumGpio-1:0]  pad_in_i,
    output logic [NumGpio-1:0]  pad_out_o,
    output logic [NumGpio-1:0]  pad_oe_o,
    input  logic [NumGpio-1:0]  cio_gpio_d2p_i,
    input  logic [NumGpio-1:0]  cio_gpio_en_d2p_i,
    output logic [NumGpio-1:0]  cio_gpio_p2d_o,
    input  logic [NumGpio-1:0]  filt_en_i,
    input  logic [FiltCntW-1:0] filt_thresh_i,
    output logic [NumGpio-1:0]  edge_rise_o,
    output logic [NumGpio-1:0]  edge_fall_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NumGpio-1:0]  pad_out_q, pad_out_d;
    logic [NumGpio-1:0]  pad_oe_q,  pad_oe_d;
    logic [NumGpio-1:0]  sync_q [SyncStages];
    logic [NumGpio-1:0]  sync_d [SyncStages];
    logic [NumGpio-1:0]  stable_q, stable_d;
    logic [NumGpio-1:0]  stable_prev_q, stable_prev_d;
    logic [FiltCntW-1:0] cnt_q [NumGpio];
    logic [FiltCntW-1:0] cnt_d [NumGpio];

    logic [NumGpio-1:0]  sync_in;
    logic [NumGpio-1:0]  sync;

    // ------------------------------------------------------------------
    // Synchroniser source select
    // ------------------------------------------------------------------
    always_comb begin
`ifdef PADCTL_GPIO_LOOPBACK_EN
        // Loopback takes the registered pad output, so the selection only
        // becomes visible after the first synchroniser flop captures it.
        sync_in = loopback_i ? pad_out_q : pad_in_i;
`else
        sync_in = pad_in_i;
`endif
    end

    assign sync = sync_q[SyncStages-1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pad_out_d     = cio_gpio_d2p_i;
        pad_oe_d      = cio_gpio_en_d2p_i;
        stable_prev_d = stable_q;

        sync_d[0] = sync_in;
        for (int s = 1; s < SyncStages; s++) begin
            sync_d[s] = sync_q[s-1];
        end

        stable_d = stable_q;
        for (int i = 0; i < NumGpio; i++) begin
            cnt_d[i] = '0;
            if (!filt_en_i[i]) begin
                // Bypass: follow sync directly and keep the counter cleared,
                // which also drops any count left over from filtered mode.
                stable_d[i] = sync[i];
            end else if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filt_thresh_i) begin
                // >= rather than == so lowering T below a running count
                // commits on the next mismatching cycle.
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else begin
                // cnt < T here, so the increment cannot wrap.
                cnt_d[i] = cnt_q[i] + FiltCntW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pad_out_q     <= '0;
            pad_oe_q      <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int s = 0; s < SyncStages; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < NumGpio; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pad_out_q     <= pad_out_d;
            pad_oe_q      <= pad_oe_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int s = 0; s < SyncStages; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < NumGpio; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pad_out_o      = pad_out_q;
    assign pad_oe_o       = pad_oe_q;
    assign cio_gpio_p2d_o = stable_q;
    // stable and stable_prev reset together, so no edge appears out of reset.
    assign edge_rise_o    = stable_q & ~stable_prev_q;
    assign edge_fall_o    = ~stable_q & stable_prev_q;

endmodule

// File: doc/padctl_gpio_filter.md
PADCTL_GPIO_FILTER -- requirements
Module: padctl_gpio_filter

Interface
REQ-001 SHALL have parameter NumGpio, default 16: GPIO channel count, legal range 1..32.
REQ-002 SHALL have parameter SyncStages, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter FiltCntW, default 8: glitch-filter counter and threshold width, legal range 1..16.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i in 1 is the clock; rst_i in 1 is the synchronous active-high reset.
REQ-005 SHALL have pad_in_i in NumGpio: raw, asynchronous pad input values.
REQ-006 SHALL have pad_out_o out NumGpio: registered pad output values.
REQ-007 SHALL have pad_oe_o out NumGpio: registered pad output enables.
REQ-008 SHALL have cio_gpio_d2p_i in NumGpio: core output data.
REQ-009 SHALL have cio_gpio_en_d2p_i in NumGpio: core output enables.
REQ-010 SHALL have cio_gpio_p2d_o out NumGpio: filtered input returned to the core.
REQ-011 SHALL have filt_en_i in NumGpio: per-channel filter enable.
REQ-012 SHALL have filt_thresh_i in FiltCntW: filter threshold T, shared by all channels.
REQ-013 SHALL have edge_rise_o out NumGpio: one-cycle pulse on a filtered 0->1 transition.
REQ-014 SHALL have edge_fall_o out NumGpio: one-cycle pulse on a filtered 1->0 transition.

Function
REQ-015 SHALL register pad_out_o and pad_oe_o from cio_gpio_d2p_i and cio_gpio_en_d2p_i with 1-cycle latency; tristate buffering is outside the block.
REQ-016 SHALL pass each pad input through SyncStages flops; the last stage is "sync".
REQ-017 SHALL keep, per channel, a register "stable" (drives cio_gpio_p2d_o) and a counter cnt of FiltCntW bits.
REQ-018 SHALL behave per channel with filt_en=0 as: stable<=sync; cnt<=0; latency pad->p2d is SyncStages+1 cycles.
REQ-019 SHALL behave per channel with filt_en=1 as follows: if sync==stable then cnt<=0; else if cnt>=T then stable<=sync and cnt<=0; else cnt<=cnt+1.
REQ-020 SHALL require a mismatch to persist T+1 consecutive cycles before stable updates; T=0 gives behaviour identical to filt_en=0.
REQ-021 SHALL discard any partial count when a glitch shorter than T+1 cycles ends (cnt returns to 0) and SHALL leave stable unchanged.
REQ-022 SHALL use the >= comparison so that a T lowered below the current cnt updates stable on the next mismatching cycle; cnt SHALL never wrap.
REQ-023 SHALL clear cnt when filt_en goes 1->0, and stable SHALL then track sync from the next cycle.
REQ-024 SHALL set edge_rise_o = stable & ~stable_prev and edge_fall_o = ~stable & stable_prev, where stable_prev is stable delayed by one cycle; each pulse is exactly 1 cycle wide.
REQ-025 SHALL keep all channels fully independent; per-channel state SHALL NOT be shared except T.

Reset
REQ-026 SHALL on rst_i=1 at a clk_i edge clear all synchroniser flops, stable, stable_prev, cnt, pad_out_o and pad_oe_o to 0.
REQ-027 SHALL ensure that during and on the cycle after reset, cio_gpio_p2d_o, edge_rise_o and edge_fall_o are 0 with no spurious edge.
REQ-028 SHALL, on reset asserted mid-filter, abort the count; after release the filter restarts from cnt=0 and stable=0.

Configuration
REQ-029 SHALL, with macro PADCTL_GPIO_LOOPBACK_EN defined, add input loopback_i (1 bit); when it is 1, the synchroniser input of every channel is pad_out_o instead of pad_in_i; its selection SHALL take effect on the next clk_i edge.
REQ-030 SHALL, with PADCTL_GPIO_LOOPBACK_EN undefined, not have loopback_i and always sample pad_in_i, with no additional logic.

Verification
REQ-031 SHALL verify passthrough: filt_en=0, pad_in[3] 0->1 at cycle 0 -> p2d[3]=1 at cycle 3 (SyncStages=2), edge_rise_o[3] high for cycle 3 only.
REQ-032 SHALL verify glitch rejection: filt_en[0]=1, T=4, pad_in[0] high for 4 cycles -> p2d[0] stays 0 and no edge pulse; high for 5 cycles -> p2d[0]=1 at 2+1+4=7 cycles after the rise.
REQ-033 SHALL verify threshold drop: T=10, mismatch held 6 cycles, T changed to 3 -> stable updates on the next clk_i edge and cnt returns to 0.
REQ-034 SHALL verify reset mid-count: T=8, rst_i pulsed at mismatch cycle 5 -> all outputs 0; after release a full 9-cycle mismatch is required.
REQ-035 SHALL verify outputs: cio_gpio_d2p=0xA5A5, cio_gpio_en_d2p=0xFFFF -> pad_out_o=0xA5A5 and pad_oe_o=0xFFFF one cycle later; with PADCTL_GPIO_LOOPBACK_EN defined and loopback_i=1 -> p2d=0xA5A5 after 1+2+1 cycles.
